// File: rtl/fpu_pkg.sv
// Shared FPU definitions: sub-unit state encoding, binary32 constants and
// field-extract helpers used across the execute-stage sub-units.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_NORM,
    S_ROOT,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [31:0]        QNAN = 32'h7FC0_0000;
  localparam logic [31:0]        PINF = 32'h7F80_0000;
  localparam logic signed [9:0]  BIAS = 10'sd127;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fsqrt_step.sv
// One restoring square-root iteration: brings down two radicand bits and
// decides the next root bit by trial subtraction.
module fsqrt_step (
  input  logic [27:0] rem,
  input  logic [25:0] root,
  input  logic [1:0]  bits,
  output logic [29:0] rem_next,
  output logic [25:0] root_next
);

  logic [29:0] rem_t;
  logic [29:0] trial;
  logic [29:0] diff;
  logic        ge;

  assign rem_t = {rem, bits};
  assign trial = {2'b00, root, 2'b01};
  assign diff  = rem_t - trial;
  assign ge    = (rem_t >= trial);

  always_comb begin
    rem_next  = ge ? diff : rem_t;
    root_next = {root[24:0], ge};
  end

endmodule

// File: rtl/float_sqrt.sv
// Multi-cycle binary32 square root (RNE) for FSQRT.S, responding to the
// FPU's active-low select / registered result strobe handshake.
module float_sqrt
  import fpu_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_rst_n,
  input  logic [31:0] a,
  input  logic        enable,
  output logic [31:0] z,
  output logic        z_stb
);

  state_t             state;
  logic [31:0]        op;
  logic [22:0]        sig;      // low bits of the significand; bit 23 is 0 while normalising
  logic signed [9:0]  e;
  logic [7:0]         er;
  logic [51:0]        rad;
  logic [29:0]        rem;
  logic [25:0]        root;
  logic [4:0]         cnt;

  logic               s_op;
  logic [7:0]         e_op;
  logic [22:0]        f_op;
  logic               is_special;
  logic               is_sub;
  logic [31:0]        special_z;

  logic [23:0]        sig_ent;
  logic signed [9:0]  e_ent;
  logic [51:0]        rad_ent;
  logic [7:0]         er_ent;

  logic [29:0]        rem_n;
  logic [25:0]        root_n;

  logic               up;
  logic [24:0]        mant;
  logic [31:0]        round_z;

  assign s_op = f_sign(op);
  assign e_op = f_exp(op);
  assign f_op = f_frac(op);
  assign is_sub = (e_op == 8'h00);

  always_comb begin
    is_special = 1'b1;
    special_z  = QNAN;
    if (e_op == 8'hFF)
      special_z = (f_op != '0 || s_op) ? QNAN : PINF;
    else if (e_op == 8'h00 && f_op == '0)
      special_z = op;
    else if (s_op)
      special_z = QNAN;
    else
      is_special = 1'b0;
  end

  // Root setup is fed either straight from unpack or from the normalising
  // shift, so the last NORM edge also loads the ROOT registers.
  always_comb begin
    if (state == S_UNPACK) begin
      sig_ent = {~is_sub, f_op};
      e_ent   = is_sub ? -10'sd126 : $signed({2'b00, e_op}) - BIAS;
    end else begin
      sig_ent = {sig, 1'b0};
      e_ent   = e - 10'sd1;
    end
    rad_ent = e_ent[0] ? {sig_ent, 28'b0} : {1'b0, sig_ent, 27'b0};
    er_ent  = e_ent[8:1] + BIAS[7:0];
  end

  fsqrt_step u_step (
    .rem       (rem[27:0]),
    .root      (root),
    .bits      (rad[51:50]),
    .rem_next  (rem_n),
    .root_next (root_n)
  );

  always_comb begin
    up      = root[1] & (root[0] | (|rem) | root[2]);
    mant    = {1'b0, root[25:2]} + {24'b0, up};
    round_z = mant[24] ? {1'b0, er + 8'd1, mant[23:1]} : {1'b0, er, mant[22:0]};
  end

  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state <= S_IDLE;
      op    <= '0;
      sig   <= '0;
      e     <= '0;
      er    <= '0;
      rad   <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      z     <= '0;
      z_stb <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!enable) begin
            op    <= a;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (enable) begin
            state <= S_IDLE;
          end else if (is_special) begin
            z     <= special_z;
            state <= S_DONE;
          end else if (is_sub) begin
            sig   <= f_op;
            e     <= -10'sd126;
            state <= S_NORM;
          end else begin
            rad   <= rad_ent;
            er    <= er_ent;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            state <= S_ROOT;
          end
        end
        S_NORM: begin
          if (enable) begin
            state <= S_IDLE;
          end else if (sig_ent[23]) begin
            rad   <= rad_ent;
            er    <= er_ent;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            state <= S_ROOT;
          end else begin
            sig <= sig_ent[22:0];
            e   <= e_ent;
          end
        end
        S_ROOT: begin
          if (enable) begin
            state <= S_IDLE;
          end else begin
            rem  <= rem_n;
            root <= root_n;
            rad  <= {rad[49:0], 2'b00};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd25)
              state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (enable) begin
            state <= S_IDLE;
          end else begin
            z     <= round_z;
            z_stb <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (enable) begin
            z_stb <= 1'b0;
            state <= S_IDLE;
          end else begin
            z_stb <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/float_sqrt.md
# float_sqrt

Multi-cycle IEEE-754 single-precision square-root unit for FSQRT.S (fpusel 5'b00100). It is the responder side of the FPU's sub-unit handshake. The FPU drives an operand and an active-low select, then stalls the pipeline until this block raises its result strobe. It sits beside the other iterative sub-units (adder, divider, multiplier, converters) inside the FPU execute stage.

## Interface
- No parameters. Format is fixed at binary32; rounding is RNE only.
- g_clk    in   1   FPU clock; all state changes on its rising edge.
- g_rst_n  in   1   Reset: asynchronous, active-low.
- a        in   32  Operand; sampled only on the capture edge.
- enable   in   1   Active-low select. 0 means the FPU is requesting or holding this op.
- z        out  32  Result; valid while z_stb=1.
- z_stb    out  1   Result strobe (registered).

## Operation
- States: IDLE, UNPACK, NORM, ROOT, ROUND, DONE.
- IDLE:
  - If enable=0: capture a into an internal register and go to UNPACK.
  - Otherwise stay in IDLE.
- UNPACK: split the operand into s, E, F, then decide the next state.
- Specials, next state DONE:
  - NaN (sNaN or qNaN): z=32'h7FC00000.
  - ±0: z = the input unchanged, sign kept.
  - +inf: z=32'h7F800000.
  - s=1 and input nonzero (including -inf): z=32'h7FC00000.
- Normal input:
  - sig = {1,F} (24 bits).
  - Unbiased exponent e = E-127, held as a 10-bit signed value.
  - Next state ROOT.
- Subnormal input (E=0, F≠0):
  - sig = {0,F}, e = -126.
  - Next state NORM.
- NORM: each cycle shift sig left by 1 and decrement e, until sig[23]=1; then go to ROOT.
- ROOT entry (one cycle, same edge as the transition into ROOT):
  - 52-bit radicand: even e gives {1'b0, sig, 27'b0}; odd e gives {sig, 28'b0}.
  - Result exponent Er = (e >>> 1) + 127 (arithmetic shift).
  - Clear root and remainder.
- ROOT: restoring digit-by-digit square root, one root bit per cycle, 26 cycles total. The outputs are:
  - 26-bit root q with q[25]=1.
  - Fraction = q[24:2], guard = q[1], round = q[0].
  - sticky = (final remainder ≠ 0).
- ROUND:
  - Round up when guard & (round | sticky | q[2]).
  - Mantissa carry-out sets fraction to 0 and Er to Er+1.
  - Result sign is 0. Overflow and underflow cannot occur; the result is always normal.
  - Next state DONE.
- DONE:
  - z_stb=1 and z holds the result.
  - Stay in DONE while enable=0.
  - When enable=1: next edge go to IDLE, z_stb=0.
- Abort: enable=1 in UNPACK, NORM, ROOT or ROUND returns to IDLE on the next edge. z_stb stays 0 and z is unchanged.

## Timing
- Reset, asynchronous: state=IDLE, z=32'h0, z_stb=0, all datapath registers 0.
- Cycle counts are measured from the capture edge (edge 0) to the edge where z_stb first reads 1:
  - Specials: 2 edges (UNPACK→DONE).
  - Normal: 28 edges (UNPACK 1, ROOT 26, ROUND 1).
  - Subnormal: 28 + k edges, where k is the number of NORM shifts (1..23).
- z and z_stb change only on rising edges. They are stable across the FPU's falling-edge sample.
- Back-to-back ops need enable to go high for at least one edge; DONE does not re-capture.
- Reset asserted mid-operation gives the reset values immediately, with no partial result.

## Structure
- Shared fpu_pkg holds:
  - The state enum.
  - QNAN=32'h7FC00000, PINF=32'h7F800000, BIAS=127.
  - The binary32 field-extract helpers, reused by the other sub-units.
- One natural sub-module: fsqrt_step, a combinational single iteration.
  - Inputs: remainder, root, next two radicand bits.
  - Outputs: updated remainder and root.
  - Everything else lives in float_sqrt.

## Test plan
- a=32'h40800000 (4.0), enable held low → z_stb rises at edge 28, z=32'h40000000.
- a=32'h40000000 (2.0) → z=32'h3FB504F3 at edge 28; a=32'h41100000 (9.0) → 32'h40400000.
- Specials, each with z_stb at edge 2:
  - 32'hBF800000 → 32'h7FC00000.
  - 32'h80000000 → 32'h80000000.
  - 32'h7F800000 → 32'h7F800000.
  - 32'h7FA00000 (sNaN) → 32'h7FC00000.
- a=32'h00000001 (min subnormal) → z=32'h1A3504F3 at edge 51 (k=23).
- Start 4.0, raise enable at edge 10 → IDLE at edge 11, z_stb never rises. Then a new op 9.0 completes correctly.
- Assert g_rst_n=0 mid-ROOT → z=0 and z_stb=0 immediately; after release, a fresh 2.0 op gives 32'h3FB504F3.
